// File: rtl/shift_if.sv
`default_nettype none
// ============================================================================
// Interface : shift_if
// Purpose   : Request/result handshake bundle for the pipelined shift unit.
// Revision  : 1.0 - initial release
// ============================================================================
interface shift_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int c_shw = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_d;
    logic [c_shw-1:0]   in_shamt;
    logic [1:0]         in_op;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_q;
    logic               out_zero;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_d, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_q, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_d, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_q, out_zero, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit
// Purpose  : Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready flow
//            control and a pass-through tag.
// Revision : 1.0 - initial release
// ============================================================================
module shift_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    shift_if.slave    bus
);
    localparam int         c_shw    = $clog2(WIDTH);
    localparam logic [1:0] c_op_sll = 2'b00;
    localparam logic [1:0] c_op_srl = 2'b01;
    localparam logic [1:0] c_op_sra = 2'b10;

    // Mux level k of the shift network lives in this pipeline stage.
    function automatic int stage_of(input int k);
        return (k * STAGES) / c_shw;
    endfunction

    function automatic logic [STAGES-1:0] above_mask(input int s);
        logic [STAGES-1:0] w_m;
        w_m = '0;
        for (int j = s + 1; j < STAGES; j++) w_m[j] = 1'b1;
        return w_m;
    endfunction

    function automatic logic [WIDTH-1:0] level_op(input logic [WIDTH-1:0] x,
                                                  input logic [1:0]       op,
                                                  input int               n);
        logic [WIDTH-1:0] w_res;
        case (op)
            c_op_sll: w_res = x << n;
            c_op_srl: w_res = x >> n;
            c_op_sra: w_res = (x >> n) | (~({WIDTH{1'b1}} >> n) & {WIDTH{x[WIDTH-1]}});
            default:  w_res = (x >> n) | (x << (WIDTH - n));
        endcase
        return w_res;
    endfunction

    logic [STAGES-1:0]              r_valid;
    logic [STAGES-1:0][WIDTH-1:0]   r_data;
    logic [STAGES-1:0][c_shw-1:0]   r_shamt;
    logic [STAGES-1:0][1:0]         r_op;
    logic [STAGES-1:0][TAG_W-1:0]   r_tag;

    logic [STAGES-1:0]              w_src_valid;
    logic [STAGES-1:0][WIDTH-1:0]   w_src_data;
    logic [STAGES-1:0][c_shw-1:0]   w_src_shamt;
    logic [STAGES-1:0][1:0]         w_src_op;
    logic [STAGES-1:0][TAG_W-1:0]   w_src_tag;
    logic [STAGES-1:0][WIDTH-1:0]   w_stage_res;
    logic [STAGES-1:0]              w_adv;
    logic [STAGES-1:0]              w_load;

    // A stage advances when its result can move on: either the consumer takes
    // the output, or some stage further down is empty (bubbles collapse).
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign w_src_valid[s] = bus.in_valid;
            assign w_src_data[s]  = bus.in_d;
            assign w_src_shamt[s] = bus.in_shamt;
            assign w_src_op[s]    = bus.in_op;
            assign w_src_tag[s]   = bus.in_tag;
        end else begin : g_body
            assign w_src_valid[s] = r_valid[s-1];
            assign w_src_data[s]  = r_data[s-1];
            assign w_src_shamt[s] = r_shamt[s-1];
            assign w_src_op[s]    = r_op[s-1];
            assign w_src_tag[s]   = r_tag[s-1];
        end

        assign w_adv[s]  = r_valid[s] && (bus.out_ready || (|(~r_valid & above_mask(s))));
        assign w_load[s] = !r_valid[s] || w_adv[s];
    end

    for (genvar k = 0; k < c_shw; k++) begin : g_lvl
        localparam int c_stg   = stage_of(k);
        localparam bit c_first = (k == 0) || (stage_of(k - 1) != c_stg);
        localparam bit c_last  = (k == c_shw - 1) || (stage_of(k + 1) != c_stg);

        logic [WIDTH-1:0] w_in;
        logic [WIDTH-1:0] w_out;

        if (c_first) begin : g_first
            assign w_in = w_src_data[c_stg];
        end else begin : g_chain
            assign w_in = g_lvl[k-1].w_out;
        end

        assign w_out = w_src_shamt[c_stg][k] ? level_op(w_in, w_src_op[c_stg], 1 << k) : w_in;

        if (c_last) begin : g_tap
            assign w_stage_res[c_stg] = w_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_data  <= '0;
            r_shamt <= '0;
            r_op    <= '0;
            r_tag   <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (w_load[s]) begin
                    r_valid[s] <= w_src_valid[s];
                    // Payload only moves with a valid beat so a stalled head stays put.
                    if (w_src_valid[s]) begin
                        r_data[s]  <= w_stage_res[s];
                        r_shamt[s] <= w_src_shamt[s];
                        r_op[s]    <= w_src_op[s];
                        r_tag[s]   <= w_src_tag[s];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = w_load[0];
    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.out_q     = r_data[STAGES-1];
    assign bus.out_zero  = (r_data[STAGES-1] == '0);
    assign bus.out_tag   = r_tag[STAGES-1];

    // The last stage's shamt/op copies have no consumer.
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^{r_shamt[STAGES-1], r_op[STAGES-1]};
endmodule
`default_nettype wire

// File: tb/tb_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_unit
// Purpose  : Self-checking bench for shift_unit at STAGES = 2, 1, 3 and 5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_unit;
    localparam int c_n     = 4;
    localparam int c_depth = 16;

    function automatic int st_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 5;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        t_in_valid [c_n];
    logic [31:0] t_in_d     [c_n];
    logic [4:0]  t_in_shamt [c_n];
    logic [1:0]  t_in_op    [c_n];
    logic [3:0]  t_in_tag   [c_n];
    logic        t_out_ready[c_n];

    logic        o_in_ready [c_n];
    logic        o_out_valid[c_n];
    logic [31:0] o_out_q    [c_n];
    logic        o_out_zero [c_n];
    logic [3:0]  o_out_tag  [c_n];

    for (genvar g = 0; g < c_n; g++) begin : g_dut
        localparam int c_st = st_of(g);
        shift_if #(.WIDTH(32), .TAG_W(4)) bus ();
        shift_unit #(.WIDTH(32), .STAGES(c_st), .TAG_W(4)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
        assign bus.in_valid   = t_in_valid[g];
        assign bus.in_d       = t_in_d[g];
        assign bus.in_shamt   = t_in_shamt[g];
        assign bus.in_op      = t_in_op[g];
        assign bus.in_tag     = t_in_tag[g];
        assign bus.out_ready  = t_out_ready[g];
        assign o_in_ready[g]  = bus.in_ready;
        assign o_out_valid[g] = bus.out_valid;
        assign o_out_q[g]     = bus.out_q;
        assign o_out_zero[g]  = bus.out_zero;
        assign o_out_tag[g]   = bus.out_tag;
    end

    int total;
    int bad;
    int cyc;

    // Scoreboard: per-DUT FIFO of expected results with edges since acceptance.
    logic [31:0] sb_q  [c_n][c_depth];
    logic [3:0]  sb_tag[c_n][c_depth];
    int          sb_age[c_n][c_depth];
    int          sb_cyc[c_n][c_depth];
    int          head[c_n];
    int          tail[c_n];
    int          rcv[c_n];
    logic        acc[c_n];
    logic        held[c_n];
    logic [31:0] hq[c_n];
    logic        hz[c_n];
    logic [3:0]  ht[c_n];
    logic [31:0] last_q[c_n];
    logic        last_zero[c_n];
    logic [3:0]  last_tag[c_n];
    int          last_lat[c_n];
    int          k[c_n];

    // Result defined bit by bit from the operation's definition.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] op);
        logic [31:0] q;
        for (int i = 0; i < 32; i++) begin
            case (op)
                2'b00:   q[i] = (i >= s) ? d[i-s] : 1'b0;
                2'b01:   q[i] = (i + s < 32) ? d[i+s] : 1'b0;
                2'b10:   q[i] = (i + s < 32) ? d[i+s] : d[31];
                default: q[i] = d[(i+s)%32];
            endcase
        end
        return q;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=0x%08h expected=0x%08h", name, idx, obs, exp);
        end
    endtask

    task automatic cycle();
        int   n;
        int   h;
        logic exp_rdy;
        logic exp_vld;
        @(negedge clk);
        for (int i = 0; i < c_n; i++) begin
            n       = tail[i] - head[i];
            h       = head[i] % c_depth;
            acc[i]  = 1'b0;
            exp_rdy = (n < st_of(i)) || t_out_ready[i];
            exp_vld = (n > 0) && (sb_age[i][h] >= st_of(i));
            chk("in_ready", i, 32'(o_in_ready[i]), 32'(exp_rdy));
            chk("out_valid", i, 32'(o_out_valid[i]), 32'(exp_vld));
            if (held[i]) begin
                chk("hold_q", i, o_out_q[i], hq[i]);
                chk("hold_zero", i, 32'(o_out_zero[i]), 32'(hz[i]));
                chk("hold_tag", i, 32'(o_out_tag[i]), 32'(ht[i]));
            end
            held[i] = o_out_valid[i] && !t_out_ready[i];
            hq[i]   = o_out_q[i];
            hz[i]   = o_out_zero[i];
            ht[i]   = o_out_tag[i];
            if (o_out_valid[i] && t_out_ready[i] && n > 0) begin
                chk("q", i, o_out_q[i], sb_q[i][h]);
                chk("zero", i, 32'(o_out_zero[i]), 32'(sb_q[i][h] == 32'd0));
                chk("tag", i, 32'(o_out_tag[i]), 32'(sb_tag[i][h]));
                last_q[i]    = o_out_q[i];
                last_zero[i] = o_out_zero[i];
                last_tag[i]  = o_out_tag[i];
                last_lat[i]  = cyc - sb_cyc[i][h];
                rcv[i]++;
                head[i]++;
            end
            if (t_in_valid[i] && o_in_ready[i]) begin
                h            = tail[i] % c_depth;
                sb_q[i][h]   = ref_shift(t_in_d[i], int'(t_in_shamt[i]), t_in_op[i]);
                sb_tag[i][h] = t_in_tag[i];
                sb_age[i][h] = 0;
                sb_cyc[i][h] = cyc;
                tail[i]++;
                acc[i] = 1'b1;
            end
        end
        cyc++;
        @(posedge clk);
        for (int i = 0; i < c_n; i++)
            for (int j = head[i]; j < tail[i]; j++)
                if (sb_age[i][j%c_depth] < 1000) sb_age[i][j%c_depth]++;
        #1;
    endtask

    // Reset edge is taken with whatever inputs the caller left applied.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < c_n; i++) begin
            head[i] = 0; tail[i] = 0; held[i] = 1'b0; t_in_valid[i] = 1'b0; t_out_ready[i] = 1'b1;
        end
        @(negedge clk);
        for (int i = 0; i < c_n; i++) begin
            chk("rst_out_valid", i, 32'(o_out_valid[i]), 32'd0);
            chk("rst_in_ready", i, 32'(o_in_ready[i]), 32'd1);
            chk("rst_out_q", i, o_out_q[i], 32'd0);
            chk("rst_out_zero", i, 32'(o_out_zero[i]), 32'd1);
            chk("rst_out_tag", i, 32'(o_out_tag[i]), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dir(input string name, input logic [31:0] d, input logic [4:0] sh,
                       input logic [1:0] op, input logic [3:0] tag, input logic [31:0] expq);
        int r0;
        r0 = rcv[0];
        t_out_ready[0] = 1'b1;
        t_in_valid[0]  = 1'b1;
        t_in_d[0] = d; t_in_shamt[0] = sh; t_in_op[0] = op; t_in_tag[0] = tag;
        cycle();
        t_in_valid[0] = 1'b0;
        repeat (4) cycle();
        chk({name, "_count"}, 0, rcv[0] - r0, 32'd1);
        chk({name, "_q"}, 0, last_q[0], expq);
        chk({name, "_zero"}, 0, 32'(last_zero[0]), 32'(expq == 32'd0));
        chk({name, "_tag"}, 0, 32'(last_tag[0]), 32'(tag));
        chk({name, "_lat"}, 0, last_lat[0], 32'd2);
    endtask

    initial begin
        int   sent;
        int   r0;
        logic saw_block;
        total = 0; bad = 0; cyc = 0;
        for (int i = 0; i < c_n; i++) begin
            t_in_valid[i] = 1'b0; t_in_d[i] = '0; t_in_shamt[i] = '0; t_in_op[i] = '0;
            t_in_tag[i] = '0; t_out_ready[i] = 1'b1;
            head[i] = 0; tail[i] = 0; rcv[i] = 0; held[i] = 1'b0; k[i] = 0;
            last_q[i] = '0; last_zero[i] = 1'b0; last_tag[i] = '0; last_lat[i] = 0;
        end
        do_reset();

        dir("sra",     32'h8000_0000, 5'd4,  2'b10, 4'd3, 32'hF800_0000);
        dir("srl",     32'h8000_0000, 5'd4,  2'b01, 4'd3, 32'h0800_0000);
        dir("ror1",    32'h0000_0001, 5'd1,  2'b11, 4'd5, 32'h8000_0000);
        dir("sll31",   32'h0000_0001, 5'd31, 2'b00, 4'd6, 32'h8000_0000);
        dir("sll_out", 32'h8000_0000, 5'd1,  2'b00, 4'd7, 32'h0000_0000);
        dir("sll0",    32'hDEAD_BEEF, 5'd0,  2'b00, 4'd8, 32'hDEAD_BEEF);
        dir("srl0",    32'hDEAD_BEEF, 5'd0,  2'b01, 4'd9, 32'hDEAD_BEEF);
        dir("sra0",    32'hDEAD_BEEF, 5'd0,  2'b10, 4'd10, 32'hDEAD_BEEF);
        dir("ror0",    32'hDEAD_BEEF, 5'd0,  2'b11, 4'd11, 32'hDEAD_BEEF);

        // Eight back-to-back requests, consumer stalled for cycles 3..7.
        sent = 0; saw_block = 1'b0; r0 = rcv[0];
        for (int c = 0; c < 24; c++) begin
            t_out_ready[0] = !(c >= 3 && c <= 7);
            t_in_valid[0]  = (sent < 8);
            t_in_d[0]      = $urandom;
            t_in_shamt[0]  = 5'($urandom);
            t_in_op[0]     = 2'($urandom);
            t_in_tag[0]    = 4'(sent);
            cycle();
            if (acc[0]) sent++;
            if (t_in_valid[0] && !acc[0]) saw_block = 1'b1;
        end
        chk("stream_sent", 0, sent, 32'd8);
        chk("stream_count", 0, rcv[0] - r0, 32'd8);
        chk("stream_last_tag", 0, 32'(last_tag[0]), 32'd7);
        chk("stream_blocked", 0, 32'(saw_block), 32'd1);

        // Two requests in flight, then reset with a request presented.
        t_out_ready[0] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            t_in_valid[0] = 1'b1; t_in_d[0] = $urandom; t_in_shamt[0] = 5'($urandom);
            t_in_op[0] = 2'($urandom); t_in_tag[0] = 4'(12 + c);
            cycle();
        end
        t_in_d[0] = 32'h1234_5678; t_in_tag[0] = 4'd15;
        do_reset();
        repeat (6) cycle();
        dir("post_rst", 32'h0000_00F0, 5'd4, 2'b01, 4'd2, 32'h0000_000F);

        // Randomised sweep: every op and shift amount per DUT, random backpressure.
        for (int c = 0; c < 700; c++) begin
            for (int i = 0; i < c_n; i++) begin
                t_out_ready[i] = ($urandom_range(0, 3) != 0);
                t_in_valid[i]  = ($urandom_range(0, 3) != 0);
                t_in_d[i]      = $urandom;
                t_in_shamt[i]  = 5'(k[i]);
                t_in_op[i]     = 2'(k[i] >> 5);
                t_in_tag[i]    = 4'($urandom);
            end
            cycle();
            for (int i = 0; i < c_n; i++) if (acc[i]) k[i]++;
        end
        for (int i = 0; i < c_n; i++) begin
            t_in_valid[i] = 1'b0; t_out_ready[i] = 1'b1;
        end
        repeat (8) cycle();
        for (int i = 0; i < c_n; i++) begin
            chk("sweep_coverage", i, 32'(k[i] >= 128), 32'd1);
            chk("drained", i, tail[i] - head[i], 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
